// File: rtl/instr_pipe_ctrl_if.sv
// Stage-chain bus: fetch-side inputs plus the stage outputs and hazard stall.
// master = the environment driving fetch; slave = instr_pipe_ctrl.
interface instr_pipe_ctrl_if #(
  parameter int NUM_STAGES = 4,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16
);
  logic                         enable;
  logic                         flush;
  logic [DATA_W-1:0]            din;
  logic                         din_valid;
  logic [NUM_STAGES*DATA_W-1:0] stage_data;
  logic [NUM_STAGES-1:0]        stage_valid;
  logic                         stall;
  logic [CNT_W-1:0]             stall_cnt;

  modport master (
    output enable, flush, din, din_valid,
    input  stage_data, stage_valid, stall, stall_cnt
  );

  modport slave (
    input  enable, flush, din, din_valid,
    output stage_data, stage_valid, stall, stall_cnt
  );
endinterface

// File: rtl/instr_pipe_ctrl.sv
// Pipeline stage-register chain with valid bits, load-use stall/bubble,
// branch flush of the young stages and a saturating stall counter.
module instr_pipe_ctrl #(
  parameter int NUM_STAGES   = 4,
  parameter int DATA_W       = 32,
  parameter int FLUSH_STAGES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              srst,
  instr_pipe_ctrl_if.slave  bus
);

  localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [DATA_W-1:0]     data_q [NUM_STAGES];
  logic [DATA_W-1:0]     data_d [NUM_STAGES];
  logic [NUM_STAGES-1:0] valid_q, valid_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [6:0] op0, op1;
  logic [4:0] rd1, rs1_0, rs2_0;
  logic       use_rs1, use_rs2, hazard;

  always_comb begin
    op0     = data_q[0][6:0];
    rs1_0   = data_q[0][19:15];
    rs2_0   = data_q[0][24:20];
    op1     = data_q[1][6:0];
    rd1     = data_q[1][11:7];
    use_rs1 = !(op0 inside {OP_LUI, OP_AUIPC, OP_JAL});
    use_rs2 = op0 inside {OP_RTYPE, OP_STORE, OP_BRANCH};
    hazard  = valid_q[0] && valid_q[1] && (op1 == OP_LOAD) && (rd1 != 5'd0) &&
              ((use_rs1 && (rd1 == rs1_0)) || (use_rs2 && (rd1 == rs2_0)));
  end

  // A taken branch overrides the stall so the squashed consumer cannot hold the PC.
  assign bus.stall = hazard && !bus.flush;

  always_comb begin
    data_d[0]  = bus.din;
    valid_d[0] = bus.din_valid;
    for (int k = 1; k < NUM_STAGES; k++) begin
      data_d[k]  = data_q[k-1];
      valid_d[k] = valid_q[k-1];
    end
    cnt_d = cnt_q;
    if (bus.flush) begin
      for (int k = 0; k < FLUSH_STAGES; k++) begin
        data_d[k]  = NOP;
        valid_d[k] = 1'b0;
      end
    end else if (hazard) begin
      data_d[0]  = data_q[0];
      valid_d[0] = valid_q[0];
      data_d[1]  = NOP;
      valid_d[1] = 1'b0;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int k = 0; k < NUM_STAGES; k++) data_q[k] <= NOP;
      valid_q <= '0;
      cnt_q   <= '0;
    end else if (bus.enable) begin
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_out
    assign bus.stage_data[k*DATA_W +: DATA_W] = data_q[k];
  end
  assign bus.stage_valid = valid_q;
  assign bus.stall_cnt   = cnt_q;

endmodule
